// File: rtl/ai_fifo_rr_arb.sv
// Round-robin read arbiter over NCH show-ahead FIFOs: grants one channel at a time,
// pops up to BURST words through a single registered output stage with back-pressure.
module ai_fifo_rr_arb #(
    parameter int NCH   = 4,
    parameter int DW    = 3,
    parameter int BURST = 8
) (
    input  logic              RCLOCK,
    input  logic              RESET,
    input  logic              enable,
    input  logic [NCH-1:0]    fifo_empty,
    input  logic [NCH*DW-1:0] fifo_rdata,
    output logic [NCH-1:0]    fifo_re,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     out_data,
    output logic [2:0]        out_ch,
    output logic              grant_done,
    output logic              busy
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [6:0] BURST_C = 7'(BURST);
    localparam logic [IW-1:0] LAST_CH = IW'(NCH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        END   = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] gnt;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] pick;
    logic [6:0]    cnt;
    logic [6:0]    cnt_inc;
    logic          space;
    logic          pop;
    logic [DW-1:0] rdata_arr [NCH];

    for (genvar i = 0; i < NCH; i++) begin : g_unpack
        assign rdata_arr[i] = fifo_rdata[i*DW +: DW];
    end

    // First non-empty channel at or after ptr, wrapping modulo NCH.
    function automatic logic [IW-1:0] rr_pick(input logic [NCH-1:0] empty,
                                              input logic [IW-1:0]  ptr);
        logic [IW-1:0] sel;
        logic          found;
        int            idx;
        sel   = ptr;
        found = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NCH) begin
                idx = idx - NCH;
            end
            if (!found && !empty[IW'(idx)]) begin
                sel   = IW'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign pick    = rr_pick(fifo_empty, rr_ptr);
    assign space   = !out_valid || out_ready;
    assign cnt_inc = cnt + 7'd1;

    always_ff @(posedge RCLOCK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        pop        = 1'b0;
        fifo_re    = '0;
        grant_done = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (enable && (fifo_empty != {NCH{1'b1}})) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                pop          = !fifo_empty[gnt] && space && (cnt < BURST_C);
                fifo_re[gnt] = pop;
                // A pop in the cycle enable drops is still taken; the grant closes after it.
                if ((pop && (cnt_inc == BURST_C)) || (cnt >= BURST_C) ||
                    (fifo_empty[gnt] && space) || !enable) begin
                    state_nxt = END;
                end
            end
            END: begin
                grant_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge RCLOCK or negedge RESET) begin
        if (!RESET) begin
            gnt    <= '0;
            cnt    <= '0;
            rr_ptr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (state_nxt == DRAIN) begin
                        gnt <= pick;
                        cnt <= '0;
                    end
                end
                DRAIN: begin
                    if (pop) begin
                        cnt <= cnt_inc;
                    end
                end
                END: begin
                    rr_ptr <= (gnt == LAST_CH) ? '0 : gnt + IW'(1);
                end
                default: begin
                    cnt <= cnt;
                end
            endcase
        end
    end

    // Output holding register: loads on a pop, empties on accept with no refill.
    always_ff @(posedge RCLOCK or negedge RESET) begin
        if (!RESET) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else if (pop) begin
            out_valid <= 1'b1;
            out_data  <= rdata_arr[gnt];
            out_ch    <= 3'(gnt);
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ai_fifo_rr_arb.sv
// Directed bench for ai_fifo_rr_arb: queue-based FIFO model feeds the DUT, a monitor
// branch compares accepted words against a scoreboard of hand-computed expectations.
module tb_ai_fifo_rr_arb;

    localparam int NCH   = 4;
    localparam int DW    = 3;
    localparam int BURST = 8;

    logic              RCLOCK;
    logic              RESET;
    logic              enable;
    logic [NCH-1:0]    fifo_empty;
    logic [NCH*DW-1:0] fifo_rdata;
    logic [NCH-1:0]    fifo_re;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [2:0]        out_ch;
    logic              grant_done;
    logic              busy;

    int errors;
    int checks;
    int cyc;
    int gd_cnt;

    logic [DW-1:0] fq [NCH][$];
    logic [5:0]    expq [$];
    int            pop_ch [$];
    int            pop_cyc [$];
    logic          hv;
    logic [DW-1:0] hdata;
    logic [2:0]    hch;

    ai_fifo_rr_arb #(.NCH(NCH), .DW(DW), .BURST(BURST)) dut (
        .RCLOCK    (RCLOCK),
        .RESET     (RESET),
        .enable    (enable),
        .fifo_empty(fifo_empty),
        .fifo_rdata(fifo_rdata),
        .fifo_re   (fifo_re),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .grant_done(grant_done),
        .busy      (busy)
    );

    initial RCLOCK = 1'b0;
    always #5 RCLOCK = ~RCLOCK;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endfunction

    task automatic refresh();
        for (int i = 0; i < NCH; i++) begin
            fifo_empty[i] = (fq[i].size() == 0);
            fifo_rdata[i*DW +: DW] = (fq[i].size() == 0) ? '0 : fq[i][0];
        end
    endtask

    task automatic load(input int ch, input int n, input int start, input bit push_exp);
        logic [DW-1:0] w;
        for (int k = 0; k < n; k++) begin
            w = DW'(start + k);
            fq[ch].push_back(w);
            if (push_exp) expq.push_back({3'(ch), w});
        end
        refresh();
    endtask

    // Starts and ends on a falling edge; pops the model FIFOs the DUT read at the rising edge.
    task automatic cycle();
        logic [NCH-1:0] re_s;
        #4;
        re_s = fifo_re;
        @(posedge RCLOCK);
        #1;
        for (int i = 0; i < NCH; i++) begin
            if (re_s[i] && fq[i].size() > 0) void'(fq[i].pop_front());
        end
        refresh();
        @(negedge RCLOCK);
    endtask

    task automatic run_quiet(input int maxc, input string name);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while ((busy || out_valid || !(&fifo_empty)) && n < maxc);
        chk({name, "_quiet"}, (busy || out_valid || !(&fifo_empty)) ? 1 : 0, 0);
    endtask

    task automatic wait_pops(input int base, input int n, input int maxc, input string name);
        int k;
        k = 0;
        while ((pop_ch.size() - base) < n && k < maxc) begin
            cycle();
            k++;
        end
        chk(name, ((pop_ch.size() - base) >= n) ? 1 : 0, 1);
    endtask

    task automatic monitor();
        logic [5:0] e;
        forever begin
            @(negedge RCLOCK);
            #3;
            cyc++;
            if (fifo_re != '0) begin
                chk("re_legal", (((fifo_re & (fifo_re - 1'b1)) == '0) &&
                                 ((fifo_re & fifo_empty) == '0)) ? 1 : 0, 1);
                for (int i = 0; i < NCH; i++) begin
                    if (fifo_re[i]) begin
                        pop_ch.push_back(i);
                        pop_cyc.push_back(cyc);
                    end
                end
            end
            if (RESET && hv) chk("hold", {out_valid, out_ch, out_data}, {1'b1, hch, hdata});
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: actual ch=%0d data=%0d expected none", out_ch, out_data);
                end else begin
                    e = expq.pop_front();
                    chk("word", {out_ch, out_data}, e);
                end
            end
            hv    = out_valid && !out_ready;
            hdata = out_data;
            hch   = out_ch;
            if (grant_done) gd_cnt++;
        end
    endtask

    task automatic stimulus();
        int base;
        int base2;
        int g0;
        int gord [12] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
        int gsz  [12] = '{8, 8, 8, 8, 8, 8, 8, 8, 4, 4, 4, 4};
        int off  [NCH];
        int sch [$];
        int ssz [$];
        int sst [$];
        int sen [$];

        // Reset state and quiet idle
        @(negedge RCLOCK);
        #3;
        chk("rst_outputs", {fifo_re, out_valid, out_data, out_ch, grant_done, busy}, 0);
        @(negedge RCLOCK);
        RESET  = 1'b1;
        enable = 1'b1;
        repeat (3) cycle();
        chk("idle_busy", busy, 0);
        chk("idle_pops", pop_ch.size(), 0);

        // Three words on ch0
        base = pop_ch.size();
        g0   = gd_cnt;
        load(0, 3, 5, 1);
        run_quiet(30, "t1");
        chk("t1_pops", pop_ch.size() - base, 3);
        if (pop_ch.size() - base >= 3) chk("t1_consecutive", pop_cyc[base+2] - pop_cyc[base], 2);
        chk("t1_grant_done", gd_cnt - g0, 1);

        // All channels full: 8-word round-robin bursts
        RESET = 1'b0;
        cycle();
        RESET = 1'b1;
        base = pop_ch.size();
        for (int c = 0; c < NCH; c++) begin
            load(c, 20, c, 0);
            off[c] = 0;
        end
        for (int g = 0; g < 12; g++) begin
            for (int k = 0; k < gsz[g]; k++) begin
                expq.push_back({3'(gord[g]), DW'(gord[g] + off[gord[g]] + k)});
            end
            off[gord[g]] += gsz[g];
        end
        run_quiet(400, "t2");
        chk("t2_pops", pop_ch.size() - base, 80);
        for (int j = base; j < pop_ch.size(); j++) begin
            if (j == base || pop_ch[j] != pop_ch[j-1] || pop_cyc[j] != pop_cyc[j-1] + 1) begin
                sch.push_back(pop_ch[j]);
                ssz.push_back(1);
                sst.push_back(pop_cyc[j]);
                sen.push_back(pop_cyc[j]);
            end else begin
                ssz[ssz.size()-1] += 1;
                sen[sen.size()-1] = pop_cyc[j];
            end
        end
        chk("t2_grants", sch.size(), 12);
        for (int s = 0; s < 12 && s < sch.size(); s++) begin
            chk($sformatf("t2_grant%0d_ch", s), sch[s], gord[s]);
            chk($sformatf("t2_grant%0d_len", s), ssz[s], gsz[s]);
            if (s >= 1 && s <= 7) chk($sformatf("t2_gap%0d", s), sst[s] - sen[s-1], 3);
        end

        // Back-pressure on ch2
        base = pop_ch.size();
        load(2, 4, 1, 1);
        wait_pops(base, 1, 20, "t3_first_pop");
        out_ready = 1'b0;
        repeat (5) cycle();
        chk("t3_stall_pops", pop_ch.size() - base, 1);
        chk("t3_stall_busy", busy, 1);
        out_ready = 1'b1;
        run_quiet(40, "t3");
        chk("t3_pops", pop_ch.size() - base, 4);

        // Pointer wrap after a ch3 grant
        base = pop_ch.size();
        load(3, 2, 6, 1);
        run_quiet(30, "t4a");
        base2 = pop_ch.size();
        load(0, 1, 3, 1);
        load(3, 1, 4, 1);
        run_quiet(30, "t4b");
        chk("t4_pops", pop_ch.size() - base2, 2);
        if (pop_ch.size() - base2 >= 2) begin
            chk("t4_first_ch", pop_ch[base2], 0);
            chk("t4_second_ch", pop_ch[base2+1], 3);
        end

        // enable drops mid-grant on ch1
        base = pop_ch.size();
        g0   = gd_cnt;
        load(1, 6, 0, 1);
        wait_pops(base, 2, 20, "t5_start");
        enable = 1'b0;
        repeat (10) cycle();
        chk("t5_pops_disabled", pop_ch.size() - base, 3);
        chk("t5_grant_done", gd_cnt - g0, 1);
        chk("t5_busy", busy, 0);
        enable = 1'b1;
        run_quiet(40, "t5");
        chk("t5_total", pop_ch.size() - base, 6);
        chk("t5_grants", gd_cnt - g0, 2);

        // Reset while holding a word, then lowest channel first
        base = pop_ch.size();
        out_ready = 1'b0;
        load(2, 3, 5, 0);
        wait_pops(base, 1, 20, "t6_start");
        #2;
        RESET = 1'b0;
        #1;
        chk("t6_rst_outputs", {fifo_re, out_valid, out_data, out_ch, grant_done, busy}, 0);
        for (int i = 0; i < NCH; i++) fq[i].delete();
        refresh();
        @(negedge RCLOCK);
        RESET     = 1'b1;
        out_ready = 1'b1;
        base2 = pop_ch.size();
        load(0, 2, 3, 1);
        load(3, 2, 1, 1);
        run_quiet(40, "t6");
        chk("t6_pops", pop_ch.size() - base2, 4);
        if (pop_ch.size() - base2 >= 1) chk("t6_first_ch", pop_ch[base2], 0);

        chk("exp_left", expq.size(), 0);
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        cyc       = 0;
        gd_cnt    = 0;
        hv        = 1'b0;
        hdata     = '0;
        hch       = '0;
        RESET     = 1'b0;
        enable    = 1'b0;
        out_ready = 1'b1;
        refresh();
        fork
            monitor();
            stimulus();
            begin
                repeat (20000) @(posedge RCLOCK);
                checks++;
                errors++;
                $display("FAIL watchdog: actual=20000 cycles expected=completion");
            end
        join_any
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ai_fifo_rr_arb.md
AI_FIFO_RR_ARB -- requirements
Module: ai_fifo_rr_arb

Interface
REQ-001 Parameter NCH, default 4, SHALL set the number of FIFO channels arbitrated (2..8).
REQ-002 Parameter DW, default 3, SHALL set the data width per channel word.
REQ-003 Parameter BURST, default 8, SHALL set the maximum words popped per grant (1..64).
REQ-004 RCLOCK  input  1  SHALL be the read-side clock; all logic is in this domain.
REQ-005 RESET  input  1  SHALL be the reset: asynchronous, active-low.
REQ-006 enable  input  1  SHALL permit new grants when 1.
REQ-007 fifo_empty  input  NCH  SHALL carry the per-channel EMPTY flags of the read-side FIFOs.
REQ-008 fifo_rdata  input  NCH*DW  SHALL carry the per-channel RDATA; channel i occupies bits [i*DW +: DW].
REQ-009 fifo_re  output  NCH  SHALL carry the per-channel read enables, one-hot or zero.
REQ-010 out_valid  output  1  SHALL flag that out_data/out_ch hold a word.
REQ-011 out_ready  input  1  SHALL signal that the consumer accepts the word in a cycle where out_valid=1.
REQ-012 out_data  output  DW  SHALL carry the popped word.
REQ-013 out_ch  output  3  SHALL carry the source channel index of out_data.
REQ-014 grant_done  output  1  SHALL pulse for one cycle when a grant ends.
REQ-015 busy  output  1  SHALL be 1 whenever the FSM is not in IDLE.

Function
REQ-016 FIFO contract: a word is present on fifo_rdata[i] whenever fifo_empty[i]=0; asserting fifo_re[i] pops that word at the same RCLOCK edge (show-ahead).
REQ-017 FSM states SHALL be IDLE, DRAIN and END.
REQ-018 IDLE->DRAIN: when enable=1 and any fifo_empty bit is 0. The grant SHALL go to the first non-empty channel at or after rr_ptr, searching upward modulo NCH.
REQ-019 Grant index and word counter (0..BURST) SHALL be registered on entry to DRAIN; the counter resets to 0.
REQ-020 Output space exists when out_valid=0, or when out_valid=1 and out_ready=1.
REQ-021 In DRAIN, fifo_re[gnt] SHALL be 1 only when fifo_empty[gnt]=0, output space exists and the counter is below BURST. All other fifo_re bits SHALL be 0.
REQ-022 On each pop: out_data<=fifo_rdata[gnt], out_ch<=gnt, out_valid<=1, counter increments. Read-to-output latency is 1 cycle.
REQ-023 If out_valid=1, out_ready=1 and there is no pop in that cycle, out_valid SHALL go to 0. out_data/out_ch SHALL hold while out_valid=1 and out_ready=0.
REQ-024 DRAIN->END when any of the following holds: the counter reaches BURST; fifo_empty[gnt]=1 while output space exists; enable=0 (the pop in that same cycle is still permitted).
REQ-025 END SHALL last one cycle. In END: grant_done=1, rr_ptr<=(gnt+1) mod NCH, then transition to IDLE. No fifo_re is asserted in END or IDLE.
REQ-026 Minimum gap between consecutive grants SHALL be 2 cycles (END, IDLE).
REQ-027 A channel with fifo_empty=1 SHALL never be granted or read. Simultaneous non-empty channels SHALL be served strictly round-robin; no channel is starved beyond NCH-1 grants.
REQ-028 rr_ptr wrap: NCH-1 SHALL advance to 0. Counter arithmetic SHALL be 7 bits unsigned with no wrap.
REQ-029 Back-pressure (out_ready=0) SHALL stall popping without ending the grant or losing data.

Reset
REQ-030 On RESET=0, the block SHALL immediately set: FSM=IDLE, rr_ptr=0, counter=0, gnt=0, fifo_re=0, out_valid=0, out_data=0, out_ch=0, grant_done=0, busy=0.
REQ-031 A reset mid-DRAIN SHALL drop any held out_data word. FIFO contents are not recovered; the FIFOs share RESET.
REQ-032 After RESET is released, the first grant SHALL go to the lowest-index non-empty channel.

Verification
REQ-033 Ch0 has 3 words (5,6,7), others empty, out_ready=1 -> fifo_re[0] high 3 cycles; out_data 5,6,7 on consecutive cycles; out_ch=0; grant_done pulses once.
REQ-034 All 4 channels hold 20 words, BURST=8 -> grants run in order 0,1,2,3,0...; each grant pops exactly 8 words; 2 idle cycles occur between grants.
REQ-035 Ch2 non-empty, out_ready=0 for 5 cycles after the first pop -> only 1 pop occurs; out_data is stable for 5 cycles; popping resumes when out_ready=1 with no word lost or duplicated.
REQ-036 enable falls mid-grant on ch1 -> the grant ends after at most 1 further pop; grant_done=1; no new grant while enable=0.
REQ-037 RESET asserted while out_valid=1 in DRAIN -> all outputs are 0 and busy=0 in the same cycle; after release with ch3 and ch0 non-empty, ch0 is granted first.
REQ-038 Ch3 granted with the previous grant on ch3 -> rr_ptr becomes 0; the next search starts at ch0.
